uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Bus-mapped UART receiver; pairs with the uart_tx block on the same 16-bit address bus.
//  Oversamples serial line bit_in with the system clock, recovers 8N1 frames (start, N_BITS data LSB-first, one stop bit).
//  Holds the last good byte on data_i_bus and raises isReady until the CPU reads address uart_addr.
//  Flags framing and overrun errors. One clock domain; bit_in is asynchronous.
// PARAMETERS
//  N_BITS     8      data bits per frame
//  M          5208   clocks per bit (50 MHz / 9600 baud); must be >= 4
//  N          13     width of the bit-time counter; 2**N > M
//  uart_addr  'h22   bus address whose read strobe acknowledges the byte
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  enable      in   1       bus read/select strobe
//  addr        in   16      bus address
//  bit_in      in   1       serial line, idle high, asynchronous
//  data_i_bus  out  N_BITS  last correctly framed byte
//  isReady     out  1       unread byte present in data_i_bus
//  frame_err   out  1       last frame had stop bit == 0
//  overrun     out  1       byte completed while isReady was already 1
// BEHAVIOUR
//  Reset (rst=1 at clk edge): FSM -> IDLE; counters, shift reg, data_i_bus, isReady, frame_err, overrun -> 0.
//   Both synchronizer flops -> 1 (idle level), so no false start comes out of reset. Reset mid-frame aborts the frame.
//  Sync: bit_in passes 2 flops -> rx_s. A falling edge is rx_s==0 with the previous rx_s==1.
//  ack = enable && (addr == uart_addr), single-cycle evaluation.
//  FSM states IDLE, START, DATA, STOP (encodings in package):
//   IDLE:  on falling edge at cycle t0 -> START. cnt <= 0.
//   START: cnt counts up. At cnt == M/2-1 (integer divide), rx_s is sampled:
//          0 -> DATA, cnt <= 0, idx <= 0.
//          1 -> IDLE (glitch rejected, no flags change).
//   DATA:  at each cnt == M-1: shift rx_s into bit idx (LSB first), cnt <= 0, idx++.
//          After bit N_BITS-1 is taken -> STOP.
//   STOP:  at cnt == M-1, rx_s is sampled:
//          1 -> data_i_bus <= shift reg; isReady <= 1; frame_err <= 0;
//               overrun <= 1 if isReady was 1 and no ack this cycle.
//          0 -> frame_err <= 1; data_i_bus and isReady unchanged.
//          In both cases -> IDLE the same cycle, so a new start edge is accepted from the next cycle.
//  Sample points: the start check is at t0+M/2-1. Data bit k is at t0+M/2-1+(k+1)*M. The stop bit is at t0+M/2-1+(N_BITS+1)*M.
//  Output latency: flags and data_i_bus are registered and visible the cycle after the stop sample.
//  Ack: clears isReady and overrun next cycle. frame_err is cleared only by the next good frame or reset.
//  Ack and frame completion in the same cycle: completion wins, so isReady stays 1 with the new data and overrun is not set.
//  Ack with an address mismatch, or with enable=0, has no effect. The ack needs no handshake back; data_i_bus is stable while isReady=1 unless overrun occurs.
//  cnt never wraps: it is bounded by M-1 < 2**N. idx is sized clog2(N_BITS+1).
//  The line held low (break) gives frame_err=1, then waits in IDLE for a new falling edge (rx_s must return to 1 first).
// STRUCTURE
//  Shared package uart_pkg:
//   - rx state typedef/localparams (IDLE=0, START=1, DATA=2, STOP=3);
//   - bus address constants UART_TX_ADDR='h21 and UART_RX_ADDR='h22;
//   - default M/N constants.
//  One sub-module, rx_bit_timer: a restartable N-bit counter with ports clr, half_tick (cnt==M/2-1) and full_tick (cnt==M-1).
//   It differs from the free-running prescaler because it must realign on every start edge.
//  The synchronizer, FSM, shift register and output regs live in uart_rx.
// TESTING (use M=16, N=5 for simulation; the bench drives bit_in with 16-clock bits)
//  1. Reset, then send byte 'hA5 with a good stop bit -> isReady=1 and data_i_bus='hA5 on the cycle after the stop sample (t0+7+9*16+1); frame_err=0.
//  2. After test 1, pulse enable with addr='h22 -> isReady=0 next cycle. Pulse with addr='h21 -> isReady stays 1.
//  3. Drive bit_in low for 5 clocks only -> no state beyond START, isReady=0, no flags; then 'h3C is received correctly.
//  4. Send 'h55 with stop bit 0 -> frame_err=1, data_i_bus keeps its prior value, isReady unchanged. Then send good 'h0F -> frame_err=0.
//  5. Send 'h11 then 'h22 with no ack -> data_i_bus='h22, overrun=1. Ack -> overrun=0, isReady=0.
//  6. Assert rst mid-DATA of 'hFF -> all outputs 0 next cycle. Then send 'h81 -> received correctly.
//  7. Ack in the same cycle as the stop sample of 'h7E -> isReady=1, data='h7E, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bus addresses and default
// bit timing for a 50 MHz clock at 9600 baud.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [15:0] UART_TX_ADDR = 16'h0021;
  localparam logic [15:0] UART_RX_ADDR = 16'h0022;

  localparam int unsigned UART_N_BITS_DEFAULT = 8;
  localparam int unsigned UART_M_DEFAULT      = 5208;
  localparam int unsigned UART_N_DEFAULT      = 13;

endpackage

// File: rtl/rx_bit_timer.sv
// Restartable bit-time counter for the receiver. Unlike a free-running
// prescaler it realigns to zero whenever clr is asserted (every start edge).
module rx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned M = UART_M_DEFAULT,
  parameter int unsigned N = UART_N_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam logic [N-1:0] HALF_CNT = N'(M / 2 - 1);
  localparam logic [N-1:0] FULL_CNT = N'(M - 1);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  // The FSM clears the count on every tick it acts upon, so it never passes M-1.
  always_comb begin
    cnt_d = clr ? '0 : cnt_q + N'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign half_tick = (cnt_q == HALF_CNT);
  assign full_tick = (cnt_q == FULL_CNT);

endmodule

// File: rtl/uart_rx.sv
// Bus-mapped 8N1 UART receiver: oversamples bit_in, holds the last good byte
// until the CPU reads uart_addr, and flags framing and overrun errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned N_BITS    = UART_N_BITS_DEFAULT,
  parameter int unsigned M         = UART_M_DEFAULT,
  parameter int unsigned N         = UART_N_DEFAULT,
  parameter logic [15:0] uart_addr = UART_RX_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       addr,
  input  logic              bit_in,
  output logic [N_BITS-1:0] data_i_bus,
  output logic              isReady,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned IDX_W = $clog2(N_BITS + 1);

  rx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic fall, ack;
  logic timer_clr, half_tick, full_tick;

  rx_bit_timer #(
    .M (M),
    .N (N)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (timer_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // NOTE: the synchronizer resets to the idle line level (1), not 0, so that
  // leaving reset never looks like a falling start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bit_in;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall = rx_prev_q && !rx_s_q;
  assign ack  = enable && (addr == uart_addr);

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    timer_clr = 1'b0;

    if (ack) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      RX_IDLE: begin
        // The edge cycle itself is count 0, so the timer runs from it.
        timer_clr = !fall;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (half_tick) begin
          timer_clr = 1'b1;
          idx_d     = '0;
          state_d   = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (full_tick) begin
          timer_clr = 1'b1;
          shift_d   = {rx_s_q, shift_q[N_BITS-1:1]};
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_BITS - 1)) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (full_tick) begin
          timer_clr = 1'b1;
          state_d   = RX_IDLE;
          if (rx_s_q) begin
            // Completion overrides a same-cycle ack on isReady.
            data_d  = shift_q;
            ready_d = 1'b1;
            ferr_d  = 1'b0;
            if (ready_q && !ack) ovr_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_i_bus = data_q;
  assign isReady    = ready_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
